// File: rtl/alu_pkg.sv
// Shared ALU definitions: data width and the VeriRisc opcode encodings.
package alu_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned OPCODE_W = 3;

  typedef enum logic [OPCODE_W-1:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } opcode_e;

endpackage

// File: rtl/alu.sv
// Accumulator ALU: registered result from accumulator and memory operand,
// plus a combinational zero flag on the accumulator for SKZ.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [WIDTH-1:0]    inA,
  input  logic [WIDTH-1:0]    inB,
  output logic [WIDTH-1:0]    out,
  output logic                is_zero
);

  logic [WIDTH-1:0] result;

  // Next result; anything not a data op (including unknown codes) passes inA through.
  always_comb begin
    result = inA;
    case (opcode)
      OP_ADD:  result = WIDTH'(inA + inB);
      OP_AND:  result = inA & inB;
      OP_XOR:  result = inA ^ inB;
      OP_LDA:  result = inB;
      default: result = inA;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= '0;
    end else begin
      out <= result;
    end
  end

  assign is_zero = (inA == '0);

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: expected results are queued when stimulus is
// driven and compared one rising edge later.
module tb_alu;
  import alu_pkg::*;

  logic                clk;
  logic                rst_n;
  logic [OPCODE_W-1:0] opcode;
  logic [7:0]          inA;
  logic [7:0]          inB;
  logic [7:0]          out;
  logic                is_zero;

  int unsigned n_checks;
  int unsigned n_errors;
  logic [7:0]  exp_q[$];

  alu #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .opcode  (opcode),
    .inA     (inA),
    .inB     (inB),
    .out     (out),
    .is_zero (is_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(inA or inB or opcode or out or is_zero)
    $display("t=%0t inA=%h inB=%h opcode=%0d out=%h is_zero=%b",
             $time, inA, inB, opcode, out, is_zero);

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_alu(input logic [2:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    case (op)
      3'd2:    return sum[7:0];
      3'd3:    return a & b;
      3'd4:    return a ^ b;
      3'd5:    return b;
      default: return a;
    endcase
  endfunction

  // Drive on the falling edge and queue the expected registered result.
  task automatic drive(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    opcode = op;
    inA    = a;
    inB    = b;
    exp_q.push_back(ref_alu(op, a, b));
  endtask

  task automatic edge_check(input string tag);
    logic [7:0] exp;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 8'h00, 8'hFF);
    end else begin
      exp = exp_q.pop_front();
      check(tag, out, exp);
    end
  endtask

  initial begin
    logic [7:0] held;
    n_checks = 0;
    n_errors = 0;
    rst_n  = 1'b0;
    opcode = 3'd0;
    inA    = 8'h01;
    inB    = 8'h00;

    // Reset state and zero flag while in reset
    #2;
    check("reset_out", out, 8'h00);
    check("reset_is_zero_01", 8'(is_zero), 8'h00);
    inA = 8'h00;
    #1;
    check("reset_is_zero_00", 8'(is_zero), 8'h01);
    inA = 8'h80;
    opcode = 3'd5;
    inB = 8'hFF;
    @(posedge clk);
    #1;
    check("reset_hold_edge", out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Every opcode with inA=0x80, inB=0xFF
    for (int op = 0; op < 8; op++) begin
      drive(3'(op), 8'h80, 8'hFF);
      edge_check($sformatf("op%0d_80_FF", op));
      check($sformatf("op%0d_is_zero", op), 8'(is_zero), 8'h00);
    end

    // Zero flag follows inA without a clock edge
    @(negedge clk);
    inA = 8'h00;
    #1;
    check("is_zero_00", 8'(is_zero), 8'h01);
    inA = 8'h01;
    #1;
    check("is_zero_01", 8'(is_zero), 8'h00);

    // Latency: opcode changes mid-cycle; only the value before the edge matters
    drive(3'd2, 8'h80, 8'hFF);
    edge_check("lat_add");
    drive(3'd2, 8'hC3, 8'h5A);
    held = out;
    #2;
    opcode = 3'd3;
    void'(exp_q.pop_back());
    exp_q.push_back(ref_alu(3'd3, 8'hC3, 8'h5A));
    #1;
    check("lat_hold", out, held);
    edge_check("lat_and");

    // Boundaries, a few random patterns, and an unknown opcode
    drive(3'd2, 8'hFF, 8'h01);
    edge_check("add_wrap_zero");
    for (int i = 0; i < 6; i++) begin
      drive(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
      edge_check($sformatf("rand%0d", i));
    end
    drive(3'bxxx, 8'h3C, 8'hA5);
    edge_check("op_x_pass");
    check("op_x_is_zero", 8'(is_zero), 8'h00);

    // Reset asserted mid-cycle clears out at once and discards the pending result
    drive(3'd5, 8'h3C, 8'hA5);
    edge_check("pre_reset_lda");
    drive(3'd4, 8'h3C, 8'hA5);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_reset_out", out, 8'h00);
    void'(exp_q.pop_back());
    @(posedge clk);
    #1;
    check("mid_reset_edge", out, 8'h00);
    check("sb_drained", 8'(exp_q.size()), 8'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
